// File: rtl/sseg_scan_capture_if.sv
// Multiplexed seven-segment display bus plus the captured-frame valid/ready channel.
// master drives the display and the ready line; slave is the capture block.
interface sseg_scan_capture_if;
    logic [3:0]  anode_n;
    logic [7:0]  cathode;
    logic        out_ready;
    logic        out_valid;
    logic [15:0] out_value;
    logic [3:0]  out_dp;
    logic        pattern_err;
    logic        overrun;

    modport master (
        output anode_n, cathode, out_ready,
        input  out_valid, out_value, out_dp, pattern_err, overrun
    );

    modport slave (
        input  anode_n, cathode, out_ready,
        output out_valid, out_value, out_dp, pattern_err, overrun
    );
endinterface

// File: rtl/sseg_scan_capture.sv
// Watches a scanned 4-digit seven-segment bus, samples each digit once it has
// settled, decodes it back to hex and emits complete 16-bit frames via valid/ready.
module sseg_scan_capture #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    sseg_scan_capture_if.slave  bus
);

    typedef enum logic [1:0] {
        BLANK,
        SETTLE,
        HOLD
    } state_t;

    localparam logic [7:0] SETTLE_M1 = 8'(SETTLE_CYCLES - 1);

    state_t      state, state_nxt;
    logic [3:0]  anode_q;
    logic [7:0]  cathode_q;
    logic [7:0]  cnt;
    logic        diff;
    logic        sample;
    logic [1:0]  dig;
    logic        dec_ok;
    logic [3:0]  dec_nib;
    logic [3:0]  seen, seen_nxt;
    logic [15:0] shadow_val;
    logic [3:0]  shadow_dp;
    logic        frame_done;
    logic        valid_q;
    logic [15:0] value_q;
    logic [3:0]  dp_q;
    logic        perr_q;
    logic        ovr_q;

    function automatic logic onehot_low(input logic [3:0] a);
        logic r;
        case (a)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: r = 1'b1;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

    // diff looks at the value about to be registered, so the edge that captures
    // a change already restarts the count and picks the next state.
    always_comb begin
        diff = ({bus.anode_n, bus.cathode} != {anode_q, cathode_q});
    end

    always_comb begin
        state_nxt = state;
        sample    = 1'b0;
        if (diff) begin
            state_nxt = onehot_low(bus.anode_n) ? SETTLE : BLANK;
        end else begin
            case (state)
                SETTLE: begin
                    if (cnt >= SETTLE_M1) begin
                        sample    = 1'b1;
                        state_nxt = HOLD;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        dig = 2'd0;
        case (anode_q)
            4'b1101: dig = 2'd1;
            4'b1011: dig = 2'd2;
            4'b0111: dig = 2'd3;
            default: dig = 2'd0;
        endcase
    end

    always_comb begin
        dec_ok  = 1'b1;
        dec_nib = '0;
        case (cathode_q[6:0])
            7'h3F: dec_nib = 4'h0;
            7'h06: dec_nib = 4'h1;
            7'h5B: dec_nib = 4'h2;
            7'h4F: dec_nib = 4'h3;
            7'h66: dec_nib = 4'h4;
            7'h6D: dec_nib = 4'h5;
            7'h7D: dec_nib = 4'h6;
            7'h07: dec_nib = 4'h7;
            7'h7F: dec_nib = 4'h8;
            7'h6F: dec_nib = 4'h9;
            7'h77: dec_nib = 4'hA;
            7'h7C: dec_nib = 4'hB;
            7'h39: dec_nib = 4'hC;
            7'h5E: dec_nib = 4'hD;
            7'h79: dec_nib = 4'hE;
            7'h71: dec_nib = 4'hF;
            default: dec_ok = 1'b0;
        endcase
    end

    // A full mask is consumed the cycle after the last sample; a sample landing
    // on that same edge starts the next frame's mask.
    always_comb begin
        frame_done = (seen == '1);
        seen_nxt   = frame_done ? '0 : seen;
        if (sample && dec_ok) begin
            seen_nxt[dig] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BLANK;
            anode_q   <= 4'hF;
            cathode_q <= 8'h00;
            cnt       <= '0;
        end else begin
            state     <= state_nxt;
            anode_q   <= bus.anode_n;
            cathode_q <= bus.cathode;
            if (diff) begin
                cnt <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen       <= '0;
            shadow_val <= '0;
            shadow_dp  <= '0;
            perr_q     <= 1'b0;
        end else begin
            seen   <= seen_nxt;
            perr_q <= sample && !dec_ok;
            if (sample && dec_ok) begin
                shadow_val[{dig, 2'b00} +: 4] <= dec_nib;
                shadow_dp[dig]                <= cathode_q[7];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            value_q <= '0;
            dp_q    <= '0;
            ovr_q   <= 1'b0;
        end else begin
            if (frame_done) begin
                if (!valid_q || bus.out_ready) begin
                    valid_q <= 1'b1;
                    value_q <= shadow_val;
                    dp_q    <= shadow_dp;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (valid_q && bus.out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid   = valid_q;
    assign bus.out_value   = value_q;
    assign bus.out_dp      = dp_q;
    assign bus.pattern_err = perr_q;
    assign bus.overrun     = ovr_q;

endmodule

// File: tb/tb_sseg_scan_capture.sv
// Bench for sseg_scan_capture: run-length reference model checked every cycle,
// a table of full frames, directed corner sequences and randomized scanning.
module tb_sseg_scan_capture;

    localparam int unsigned SETTLE = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sseg_scan_capture_if bus();

    sseg_scan_capture #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    function automatic void decode_ref(input logic [6:0] p, output logic ok, output logic [3:0] n);
        ok = 1'b0;
        n  = '0;
        for (int k = 0; k < 16; k++) begin
            if (seg_tab[k] == p) begin
                ok = 1'b1;
                n  = 4'(k);
            end
        end
    endfunction

    // Reference model: a digit is taken when the same bus value has been captured
    // on exactly SETTLE+1 consecutive edges with a single anode low.
    logic [11:0] m_in = 12'hF00;
    int          m_run = 0;
    logic [3:0]  m_seen = '0;
    logic [3:0]  m_nib [4];
    logic        m_dpv [4];
    logic        m_valid = 1'b0;
    logic [15:0] m_value = '0;
    logic [3:0]  m_dp = '0;
    logic        m_ovr = 1'b0;
    logic        m_perr = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_in = 12'hF00; m_run = 0; m_seen = '0;
            for (int k = 0; k < 4; k++) begin m_nib[k] = '0; m_dpv[k] = 1'b0; end
            m_valid = 1'b0; m_value = '0; m_dp = '0; m_ovr = 1'b0; m_perr = 1'b0;
        end else begin
            automatic logic complete = (m_seen == 4'hF);
            automatic logic old_valid = m_valid;
            automatic logic [11:0] cur = {bus.anode_n, bus.cathode};
            automatic int zeros = 0;
            automatic int idx = 0;
            automatic logic ok;
            automatic logic [3:0] nib;
            if (complete) begin
                if (!old_valid || bus.out_ready) begin
                    m_valid = 1'b1;
                    m_value = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
                    m_dp    = {m_dpv[3], m_dpv[2], m_dpv[1], m_dpv[0]};
                end else begin
                    m_ovr = 1'b1;
                end
                m_seen = '0;
            end else if (old_valid && bus.out_ready) begin
                m_valid = 1'b0;
            end
            if (cur == m_in) begin
                if (m_run < 1000) m_run++;
            end else begin
                m_in  = cur;
                m_run = 1;
            end
            m_perr = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (!m_in[8 + k]) begin zeros++; idx = k; end
            end
            if (m_run == int'(SETTLE) + 1 && zeros == 1) begin
                decode_ref(m_in[6:0], ok, nib);
                if (ok) begin
                    m_nib[idx] = nib;
                    m_dpv[idx] = m_in[7];
                    m_seen[idx] = 1'b1;
                end else begin
                    m_perr = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_valid", 32'(bus.out_valid), 32'd0);
            check("rst_value", 32'(bus.out_value), 32'd0);
            check("rst_dp", 32'(bus.out_dp), 32'd0);
            check("rst_perr", 32'(bus.pattern_err), 32'd0);
            check("rst_overrun", 32'(bus.overrun), 32'd0);
        end else begin
            check("valid", 32'(bus.out_valid), 32'(m_valid));
            check("value", 32'(bus.out_value), 32'(m_value));
            check("dp", 32'(bus.out_dp), 32'(m_dp));
            check("perr", 32'(bus.pattern_err), 32'(m_perr));
            check("overrun", 32'(bus.overrun), 32'(m_ovr));
        end
    end

    int          frames = 0;
    int          perrs = 0;
    logic [15:0] last_val = '0;
    logic [3:0]  last_dp = '0;

    always @(posedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            frames++;
            last_val = bus.out_value;
            last_dp  = bus.out_dp;
        end
        if (rst_n && bus.pattern_err) perrs++;
    end

    task automatic scan(input int d, input logic [7:0] pat, input int hold);
        @(negedge clk);
        bus.anode_n = ~(4'b0001 << d);
        bus.cathode = pat;
        repeat (hold) @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [31:0] pats;
        logic [15:0] value;
        logic [3:0]  dp;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, p0, first;
        // pats holds digit3..digit0 cathode bytes, msb first.
        vecs[0] = '{32'h664F5B06, 16'h4321, 4'b0000};
        vecs[1] = '{32'h4F5B063F, 16'h3210, 4'b0000};
        vecs[2] = '{32'h877DED66, 16'h7654, 4'b1010};
        vecs[3] = '{32'hFCF7EFFF, 16'hBA98, 4'b1111};
        vecs[4] = '{32'h71795EB9, 16'hFEDC, 4'b0001};

        bus.anode_n = 4'hF;
        bus.cathode = 8'h00;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Settle latency: last digit of a frame, observed through frame completion.
        scan(1, 8'h06, 8); scan(2, 8'h06, 8); scan(3, 8'h06, 8);
        f0 = frames; p0 = perrs; first = 0;
        @(negedge clk);
        bus.anode_n = 4'b1110;
        bus.cathode = 8'h7F;
        for (int e = 1; e <= 10; e++) begin
            @(negedge clk);
            if (bus.out_valid && first == 0) first = e;
        end
        check("t1_latency", 32'(first), 32'(SETTLE + 2));
        check("t1_frames", 32'(frames), 32'(f0 + 1));
        check("t1_value", 32'(last_val), 32'h1118);
        check("t1_perr", 32'(perrs), 32'(p0));

        for (int v = 0; v < 5; v++) begin
            f0 = frames;
            for (int d = 0; d < 4; d++) begin
                automatic logic [31:0] pw = vecs[v].pats;
                scan(d, pw[8*d +: 8], 8);
            end
            check("tab_frames", 32'(frames), 32'(f0 + 1));
            check("tab_value", 32'(last_val), 32'(vecs[v].value));
            check("tab_dp", 32'(last_dp), 32'(vecs[v].dp));
        end

        // Invalid pattern on digit 2, then repaired.
        f0 = frames; p0 = perrs;
        scan(0, 8'h3F, 8); scan(1, 8'h06, 8); scan(2, 8'h00, 8); scan(3, 8'h5B, 8);
        check("t3_perr", 32'(perrs), 32'(p0 + 1));
        check("t3_noframe", 32'(frames), 32'(f0));
        scan(2, 8'h7D, 8);
        check("t3_frames", 32'(frames), 32'(f0 + 1));
        check("t3_value", 32'(last_val), 32'h2610);

        // Two anodes low with a toggling cathode never samples.
        f0 = frames; p0 = perrs;
        @(negedge clk);
        bus.anode_n = 4'b1100;
        for (int t = 0; t < 10; t++) begin
            bus.cathode = t[0] ? 8'h5B : 8'h06;
            repeat (2) @(negedge clk);
        end
        scan(0, 8'h06, 8); scan(1, 8'h06, 8); scan(2, 8'h06, 8);
        check("t4_noframe", 32'(frames), 32'(f0));
        check("t4_perr", 32'(perrs), 32'(p0));
        scan(3, 8'h06, 8);
        check("t4_frame", 32'(frames), 32'(f0 + 1));
        check("t4_value", 32'(last_val), 32'h1111);

        for (int s = 0; s < 400; s++) begin
            @(negedge clk);
            if ($urandom_range(0, 99) < 85) bus.anode_n = ~(4'b0001 << $urandom_range(0, 3));
            else bus.anode_n = 4'($urandom);
            if ($urandom_range(0, 99) < 80) bus.cathode = {1'($urandom_range(0, 1)), seg_tab[$urandom_range(0, 15)]};
            else bus.cathode = 8'($urandom);
            bus.out_ready = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 10)) @(posedge clk);
        end

        // Back-pressure: second frame dropped, first held.
        do_reset();
        bus.out_ready = 1'b0;
        f0 = frames;
        scan(0, 8'h5E, 8); scan(1, 8'h39, 8); scan(2, 8'h7C, 8); scan(3, 8'h77, 8);
        scan(0, 8'h66, 8); scan(1, 8'h4F, 8); scan(2, 8'h5B, 8); scan(3, 8'h06, 8);
        @(negedge clk);
        check("t5_valid", 32'(bus.out_valid), 32'd1);
        check("t5_value", 32'(bus.out_value), 32'hABCD);
        check("t5_overrun", 32'(bus.overrun), 32'd1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("t5_drop", 32'(bus.out_valid), 32'd0);
        check("t5_accepted", 32'(frames), 32'(f0 + 1));

        // Reset mid-frame discards partial digits.
        scan(0, 8'h3F, 8); scan(1, 8'h06, 8); scan(2, 8'h5B, 8);
        do_reset();
        f0 = frames;
        scan(0, 8'h7F, 8); scan(1, 8'h7F, 8); scan(2, 8'h7F, 8);
        check("t6_noframe", 32'(frames), 32'(f0));
        scan(3, 8'h7F, 8);
        check("t6_frames", 32'(frames), 32'(f0 + 1));
        check("t6_value", 32'(last_val), 32'h8888);
        check("t6_overrun", 32'(bus.overrun), 32'd0);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sseg_scan_capture.md
Name: sseg_scan_capture

Overview:
- Receive-side counterpart of the seven-segment decoder: it monitors a multiplexed 4-digit display bus (active-low digit anodes, 8-bit segment pattern) and reconstructs the displayed hex value.
- Each stable digit slot is sampled once and its segment pattern is mapped back to a 4-bit nibble.
- When all four digits of a frame have been captured, the 16-bit value is presented on a valid/ready output.
- Used as a display-loopback checker and readback path.

Parameters:
SETTLE_CYCLES, 4, consecutive cycles the registered anode/cathode pair must be unchanged before sampling (legal range 1..255).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
anode_n  input  4  digit select, active low; bit i low = digit i driven
cathode  input  8  segment pattern, 1 = lit; [7]=DP, [6:0]={g,f,e,d,c,b,a}
out_ready  input  1  consumer accepts frame
out_valid  output  1  frame available
out_value  output  16  digit i in bits [4i+3:4i]
out_dp  output  4  DP state per digit
pattern_err  output  1  one-cycle pulse: stable pattern not in table
overrun  output  1  sticky: completed frame dropped while out_valid=1 and out_ready=0

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_value=0, out_dp=0, pattern_err=0, overrun=0, seen mask=0, FSM=BLANK, input regs=8'h00/4'hF, counter=0.
- anode_n and cathode are registered every cycle into in_q. The stability counter clears whenever in_q differs from its previous value, otherwise it increments and saturates.
- Decode table on cathode[6:0]; any other pattern is invalid:
  - 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7
  - 7F=8, 6F=9, 77=A, 7C=b, 39=C, 5E=d, 79=E, 71=F
- DP (cathode[7]) never affects the decoded value.
- FSM:
  - BLANK: registered anode_n not one-hot-low (all 1s or more than one 0). No sampling. Go to SETTLE when anode_n becomes one-hot-low.
  - SETTLE: counting stability. Any in_q change restarts the count; a change to non-one-hot anode_n goes to BLANK. When in_q has been unchanged for SETTLE_CYCLES consecutive edges, sample on that edge and go to HOLD.
  - HOLD: the slot has already been sampled, so no resampling. Any in_q change goes to SETTLE (or BLANK if anode_n is not one-hot-low).
- Sample action:
  - Valid pattern: store nibble and DP into the shadow digit i, set seen[i]. A digit re-sampled within the same frame is overwritten.
  - Invalid pattern: pulse pattern_err for one cycle; seen[i] unchanged.
- Latency: inputs change once and then hold → the shadow digit is updated SETTLE_CYCLES+1 edges after the first edge that sees the change.
- Frame complete (seen=1111, evaluated the cycle after the last sample):
  - If out_valid=0, or out_valid&&out_ready in that same cycle: load out_value/out_dp from the shadow, set out_valid=1, clear seen.
  - Otherwise: set overrun, clear seen, discard the frame.
- Handshake:
  - out_value and out_dp are stable while out_valid=1.
  - out_valid&&out_ready with no new frame completing → out_valid=0 next cycle.
  - Acceptance and a new frame load in the same cycle → out_valid stays 1 and out_value takes the new frame.
- overrun clears only on reset.
- Reset mid-settle or mid-frame discards all partial state immediately.

Test Plan:
1. SETTLE_CYCLES=4; anode_n=1110, cathode=8'b01111111 held 10 cycles → shadow digit0=8 at edge 5 after the change, no resample, pattern_err stays 0.
2. Scan digits 0..3 with patterns 06,5B,4F,66, each held 8 cycles, out_ready=1 → one out_valid pulse with out_value=16'h4321, out_dp=0000.
3. Digit 2 pattern 8'h00 held 8 cycles → single pattern_err pulse, no frame emitted. Then rescan digit 2 with 8'h7D → frame emitted with nibble 6 in [11:8].
4. Cathode toggles every 2 cycles with SETTLE_CYCLES=4; anode_n=1100 (two digits selected) → no sample, seen stays 0.
5. out_ready=0 with two full frames 16'hABCD then 16'h1234 → out_value holds ABCD and overrun=1. Then out_ready=1 → out_valid drops the next cycle.
6. Assert rst_n=0 after three digits have been captured, release, then scan a full frame of 8s → out_value=16'h8888, and no stale digits appear.
